reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter OP_W, default 4, opcode width.
REQ-002 Parameter TAG_W, default 6, ROB tag width.
REQ-003 Parameter DATA_W, default 16, operand/result width.
REQ-004 Parameter ENTRIES, default 4, station depth (>=2).
REQ-005 Parameter NUM_FWD, default 4, number of result-forward buses.
REQ-006 Operation word OPW = OP_W+3*TAG_W+2*DATA_W+2, packed MSB->LSB: opcode, rob, tagA, tagB, valueA, valueB, waitA, waitB. waitX=1 means the operand is pending on tagX.
REQ-007 Forward word FW = 1+TAG_W+DATA_W, packed MSB->LSB: valid, tag, value.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 reset  input  1  synchronous, active-high.
REQ-010 flush  input  1  discard all entries (mispredict recovery).
REQ-011 in_valid  input  1  insert request.
REQ-012 in_ready  output  1  station can accept an insert.
REQ-013 in_operation  input  OPW  operation to insert.
REQ-014 fwd_bus  input  NUM_FWD*FW  forward buses; bus 0 occupies the least significant bits.
REQ-015 out_valid  output  1  an issue-eligible entry is presented.
REQ-016 out_ready  input  1  downstream unit accepts the presented entry.
REQ-017 out_operation  output  OPW  operation being issued; waitA=waitB=0.
REQ-018 count  output  $clog2(ENTRIES+1)  occupied entries.

Function
REQ-019 Storage SHALL be a compacting queue; slot 0 is always the oldest, occupied slots are contiguous from slot 0.
REQ-020 Every cycle, each occupied entry with waitX=1 SHALL compare tagX against every valid forward bus; on a match it SHALL latch that bus value into valueX and clear waitX.
REQ-021 When several buses match the same operand, the lowest-indexed bus SHALL win.
REQ-022 Entries with waitX=0 SHALL ignore forward buses for operand X.
REQ-023 An insert SHALL occur when in_valid && in_ready; the inserted entry SHALL receive the same forward check (REQ-020/021) against the fwd_bus of the insert cycle.
REQ-024 in_ready SHALL equal (count < ENTRIES) && !flush; an insert into a full station SHALL NOT be accepted, even when an issue happens in the same cycle.
REQ-025 An entry SHALL be issue-eligible when it is occupied and both wait bits are 0 in registered state. An entry inserted in cycle N SHALL be eligible no earlier than cycle N+1.
REQ-026 out_valid SHALL be 1 iff any entry is eligible; out_operation SHALL be the lowest-indexed (oldest) eligible entry.
REQ-027 out_valid and out_operation MAY change while out_ready=0, because an older entry can become eligible; consumers SHALL sample only on out_valid && out_ready.
REQ-028 An issue SHALL occur on out_valid && out_ready && !flush; the issued slot SHALL be removed and all younger slots SHALL shift down one position in the same edge.
REQ-029 On simultaneous insert and issue, the shift SHALL happen first, and the new entry SHALL be written to slot (count-1); count SHALL stay unchanged.
REQ-030 count SHALL be incremented by an insert alone, decremented by an issue alone, and unchanged by both or neither.
REQ-031 flush SHALL clear all entries, count becomes 0, and SHALL override insert and issue in the same cycle; out_valid SHALL be 0 while flush=1.
REQ-032 Forward values SHALL be captured during a shift, so that no forward is lost by an entry that moves.

Reset
REQ-033 On reset, all slots SHALL become unoccupied, with count=0, out_valid=0, in_ready=1 from the next cycle, out_operation=0.
REQ-034 Reset SHALL take priority over flush, insert, issue and forwarding.

Configuration
REQ-035 Macro RS_ISSUE_BYPASS_EN.
- Defined: an occupied entry whose last pending operand(s) match a forward bus in the current cycle SHALL be issue-eligible in that cycle, with the forwarded value driven on out_operation (combinational path).
- Undefined: eligibility SHALL use registered wait bits only (REQ-025), and out_operation SHALL come directly from registers.
REQ-036 Insert-cycle eligibility (REQ-025) SHALL be unchanged by the macro.

Verification
REQ-037 Insert op=3 rob=5 tagA=9 waitA=1 valueB=0x0010 waitB=0, then fwd bus2 {1,9,0x1234} -> next cycle out_valid=1, valueA=0x1234, waits 00. With RS_ISSUE_BYPASS_EN, out_valid=1 in the forward cycle.
REQ-038 Bus0 and bus3 both carry tag 9 (0xAAAA, 0xBBBB) -> the waiting entry captures 0xAAAA.
REQ-039 Fill 4 entries, all pending, hold in_valid -> in_ready=0, count=4, no overwrite. Forward rob of slot 2 only, out_ready=1 -> slot 2 issues, slots 3->2, count=3.
REQ-040 count=2 with slot 0 ready, insert and out_ready in the same cycle -> slot 0 issues, old slot 1 moves to slot 0, new entry lands in slot 1, count=2.
REQ-041 flush=1 with in_valid=1, out_ready=1, count=3 -> next cycle count=0, out_valid=0, and the insert is dropped.
REQ-042 Reset asserted mid-operation with count=3 -> next cycle count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/reservation_station.sv
// Compacting reservation station: oldest-first issue with operand capture from forward buses.
// Optional RS_ISSUE_BYPASS_EN lets an entry issue in the same cycle its last operand is forwarded.
module reservation_station #(
    parameter int OP_W    = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 16,
    parameter int ENTRIES = 4,
    parameter int NUM_FWD = 4,
    localparam int OPW    = OP_W + 3*TAG_W + 2*DATA_W + 2,
    localparam int FW     = 1 + TAG_W + DATA_W,
    localparam int CW     = $clog2(ENTRIES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPW-1:0]        in_operation,
    input  logic [NUM_FWD*FW-1:0] fwd_bus,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPW-1:0]        out_operation,
    output logic [CW-1:0]         count
);

    localparam int IW     = $clog2(ENTRIES);
    localparam int VB_LSB = 2;
    localparam int VA_LSB = 2 + DATA_W;
    localparam int TB_LSB = 2 + 2*DATA_W;
    localparam int TA_LSB = TB_LSB + TAG_W;

    logic [OPW-1:0]     op_q   [ENTRIES];
    logic [OPW-1:0]     op_d   [ENTRIES];
    logic [OPW-1:0]     fwd_op [ENTRIES];
    logic [CW-1:0]      count_q, count_d, cnt_shift;
    logic [ENTRIES-1:0] eligible;
    logic [IW-1:0]      sel;
    logic               any_elig, issue, insert;
    logic [OPW-1:0]     in_fwd;

    // Lowest-indexed valid bus with a matching tag wins for each pending operand.
    function automatic logic [OPW-1:0] fwd_apply(input logic [OPW-1:0] op,
                                                 input logic [NUM_FWD*FW-1:0] bus);
        logic [OPW-1:0] r;
        logic [FW-1:0]  f;
        logic           hit_a, hit_b;
        r     = op;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int b = 0; b < NUM_FWD; b++) begin
            f = bus[b*FW +: FW];
            if (f[FW-1] && op[1] && !hit_a && f[DATA_W +: TAG_W] == op[TA_LSB +: TAG_W]) begin
                r[VA_LSB +: DATA_W] = f[DATA_W-1:0];
                r[1]  = 1'b0;
                hit_a = 1'b1;
            end
            if (f[FW-1] && op[0] && !hit_b && f[DATA_W +: TAG_W] == op[TB_LSB +: TAG_W]) begin
                r[VB_LSB +: DATA_W] = f[DATA_W-1:0];
                r[0]  = 1'b0;
                hit_b = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        eligible = '0;
        sel      = '0;
        any_elig = 1'b0;
        for (int j = 0; j < ENTRIES; j++) begin
            fwd_op[j] = fwd_apply(op_q[j], fwd_bus);
`ifdef RS_ISSUE_BYPASS_EN
            eligible[j] = (CW'(j) < count_q) && !fwd_op[j][1] && !fwd_op[j][0];
`else
            eligible[j] = (CW'(j) < count_q) && !op_q[j][1] && !op_q[j][0];
`endif
        end
        for (int j = ENTRIES-1; j >= 0; j--) begin
            if (eligible[j]) begin
                sel      = IW'(j);
                any_elig = 1'b1;
            end
        end

        out_valid     = any_elig && !flush;
        out_operation = '0;
        if (any_elig) begin
`ifdef RS_ISSUE_BYPASS_EN
            out_operation = fwd_op[sel];
`else
            out_operation = op_q[sel];
`endif
        end

        in_ready  = (count_q < CW'(ENTRIES)) && !flush;
        insert    = in_valid && in_ready;
        issue     = out_valid && out_ready;
        in_fwd    = fwd_apply(in_operation, fwd_bus);
        cnt_shift = count_q - CW'(issue);

        // Shift uses the forwarded view so a moving entry keeps this cycle's captures.
        for (int j = 0; j < ENTRIES; j++) begin
            if (issue && IW'(j) >= sel)
                op_d[j] = (j == ENTRIES-1) ? '0 : fwd_op[(j+1) % ENTRIES];
            else
                op_d[j] = fwd_op[j];
            if (insert && CW'(j) == cnt_shift)
                op_d[j] = in_fwd;
        end
        count_d = cnt_shift + CW'(insert);

        if (flush) begin
            count_d = '0;
            for (int j = 0; j < ENTRIES; j++)
                op_d[j] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int j = 0; j < ENTRIES; j++)
                op_q[j] <= '0;
        end else begin
            count_q <= count_d;
            for (int j = 0; j < ENTRIES; j++)
                op_q[j] <= op_d[j];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed table-driven bench for reservation_station; each row is one cycle,
// outputs are checked just before the rising edge that consumes the row's inputs.
module tb_reservation_station;

    localparam int OPW = 4 + 3*6 + 2*16 + 2;
    localparam int FW  = 1 + 6 + 16;
    localparam int NFW = 4*FW;
`ifdef RS_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset, flush, in_valid, out_ready;
    logic           in_ready, out_valid;
    logic [OPW-1:0] in_operation, out_operation;
    logic [NFW-1:0] fwd_bus;
    logic [2:0]     count;

    int checks   = 0;
    int failures = 0;

    reservation_station dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_operation(in_operation),
        .fwd_bus(fwd_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_operation(out_operation),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst, fl, iv;
        logic [OPW-1:0] op;
        logic [NFW-1:0] fwd;
        logic           ordy;
        logic [2:0]     cnt;
        logic           irdy;
        logic           ov;
        logic [OPW-1:0] oop;
        logic           ov_b;
        logic [OPW-1:0] oop_b;
    } vec_t;

    vec_t vq[$];

    function automatic logic [OPW-1:0] mk_op(input logic [3:0] opc, input logic [5:0] rob,
            input logic [5:0] ta, input logic [5:0] tb, input logic [15:0] va,
            input logic [15:0] vb, input logic wa, input logic wb);
        return {opc, rob, ta, tb, va, vb, wa, wb};
    endfunction

    function automatic logic [NFW-1:0] mk_fwd(input int b, input logic v,
            input logic [5:0] t, input logic [15:0] val);
        logic [NFW-1:0] r;
        r = '0;
        r[b*FW +: FW] = {v, t, val};
        return r;
    endfunction

    task automatic add(input logic rst, input logic fl, input logic iv, input logic [OPW-1:0] op,
            input logic [NFW-1:0] fwd, input logic ordy, input logic [2:0] cnt, input logic irdy,
            input logic ov, input logic [OPW-1:0] oop, input logic ov_b, input logic [OPW-1:0] oop_b);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.op = op; v.fwd = fwd; v.ordy = ordy;
        v.cnt = cnt; v.irdy = irdy; v.ov = ov; v.oop = oop; v.ov_b = ov_b; v.oop_b = oop_b;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    logic [OPW-1:0] Z, A, A_D, B, B_D, C, C_D, X, R0, Q1, Q1_D, N, P2_D, P3_D;
    logic [OPW-1:0] P [4];
    logic [NFW-1:0] F0;
    logic           e_ov;
    logic [OPW-1:0] e_oop;

    initial begin
        Z    = '0;
        F0   = '0;
        A    = mk_op(3, 5, 9, 0, 16'h0000, 16'h0010, 1, 0);
        A_D  = mk_op(3, 5, 9, 0, 16'h1234, 16'h0010, 0, 0);
        B    = mk_op(1, 7, 9, 0, 16'h0000, 16'h0022, 1, 0);
        B_D  = mk_op(1, 7, 9, 0, 16'hAAAA, 16'h0022, 0, 0);
        C    = mk_op(2, 1, 3, 4, 16'h0000, 16'h0000, 1, 1);
        C_D  = mk_op(2, 1, 3, 4, 16'h0333, 16'h0444, 0, 0);
        X    = mk_op(15, 63, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
        R0   = mk_op(4, 20, 0, 0, 16'h0040, 16'h0041, 0, 0);
        Q1   = mk_op(5, 21, 30, 0, 16'h0000, 16'h0051, 1, 0);
        Q1_D = mk_op(5, 21, 30, 0, 16'h3030, 16'h0051, 0, 0);
        N    = mk_op(6, 22, 0, 0, 16'h0060, 16'h0061, 0, 0);
        for (int i = 0; i < 4; i++)
            P[i] = mk_op(4'(i), 6'(10+i), 6'(20+i), 0, 16'h0000, 16'(i), 1, 0);
        P2_D = mk_op(2, 12, 22, 0, 16'h2222, 16'h0002, 0, 0);
        P3_D = mk_op(3, 13, 23, 0, 16'h3333, 16'h0003, 0, 0);

        //   rst fl iv op  fwd                                  ordy cnt irdy ov oop   ov_b oop_b
        add(0, 0, 1, A,  F0,                                     0,   0,  1,  0, Z,    0, Z);
        add(0, 0, 0, Z,  mk_fwd(2, 1, 9, 16'h1234),              0,   1,  1,  0, Z,    1, A_D);
        add(0, 0, 0, Z,  F0,                                     0,   1,  1,  1, A_D,  1, A_D);
        add(0, 0, 0, Z,  F0,                                     1,   1,  1,  1, A_D,  1, A_D);
        add(0, 0, 0, Z,  F0,                                     0,   0,  1,  0, Z,    0, Z);
        add(0, 0, 1, B,  F0,                                     0,   0,  1,  0, Z,    0, Z);
        add(0, 0, 0, Z,  mk_fwd(0, 1, 9, 16'hAAAA) | mk_fwd(3, 1, 9, 16'hBBBB),
                                                                 0,   1,  1,  0, Z,    1, B_D);
        add(0, 0, 0, Z,  F0,                                     1,   1,  1,  1, B_D,  1, B_D);
        add(0, 0, 1, C,  mk_fwd(0, 0, 3, 16'hDEAD) | mk_fwd(1, 1, 3, 16'h0333) | mk_fwd(2, 1, 4, 16'h0444),
                                                                 1,   0,  1,  0, Z,    0, Z);
        add(0, 0, 0, Z,  F0,                                     1,   1,  1,  1, C_D,  1, C_D);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, P[i], F0,                               1,   3'(i), 1, 0, Z,  0, Z);
        add(0, 0, 1, X,  F0,                                     1,   4,  0,  0, Z,    0, Z);
        add(0, 0, 1, X,  mk_fwd(1, 1, 22, 16'h2222),             0,   4,  0,  0, Z,    1, P2_D);
        add(0, 0, 1, X,  F0,                                     1,   4,  0,  1, P2_D, 1, P2_D);
        add(0, 0, 0, Z,  mk_fwd(0, 1, 23, 16'h3333),             0,   3,  1,  0, Z,    1, P3_D);
        add(0, 0, 0, Z,  F0,                                     0,   3,  1,  1, P3_D, 1, P3_D);
        add(0, 1, 1, X,  F0,                                     1,   3,  0,  0, Z,    0, Z);
        add(0, 0, 0, Z,  F0,                                     0,   0,  1,  0, Z,    0, Z);
        add(0, 0, 1, R0, F0,                                     0,   0,  1,  0, Z,    0, Z);
        add(0, 0, 1, Q1, F0,                                     0,   1,  1,  1, R0,   1, R0);
        add(0, 0, 1, N,  F0,                                     1,   2,  1,  1, R0,   1, R0);
        add(0, 0, 0, Z,  F0,                                     0,   2,  1,  1, N,    1, N);
        add(0, 0, 0, Z,  mk_fwd(3, 1, 30, 16'h3030),             0,   2,  1,  1, N,    1, Q1_D);
        add(0, 0, 0, Z,  F0,                                     1,   2,  1,  1, Q1_D, 1, Q1_D);
        add(0, 0, 0, Z,  F0,                                     1,   1,  1,  1, N,    1, N);
        add(0, 0, 0, Z,  F0,                                     0,   0,  1,  0, Z,    0, Z);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_operation = '0; fwd_bus = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_operation", 64'(out_operation), 64'd0);

        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            reset        = vq[k].rst;
            flush        = vq[k].fl;
            in_valid     = vq[k].iv;
            in_operation = vq[k].op;
            fwd_bus      = vq[k].fwd;
            out_ready    = vq[k].ordy;
            #1;
            e_ov  = BYP ? vq[k].ov_b  : vq[k].ov;
            e_oop = BYP ? vq[k].oop_b : vq[k].oop;
            chk($sformatf("row%0d_count", k), 64'(count), 64'(vq[k].cnt));
            chk($sformatf("row%0d_in_ready", k), 64'(in_ready), 64'(vq[k].irdy));
            chk($sformatf("row%0d_out_valid", k), 64'(out_valid), 64'(e_ov));
            if (e_ov)
                chk($sformatf("row%0d_out_operation", k), 64'(out_operation), 64'(e_oop));
        end

        // Reset in the middle of activity, with insert and issue requests pending.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_operation = P[i]; out_ready = 1'b0; fwd_bus = '0;
        end
        @(negedge clk);
        in_valid = 1'b1; in_operation = X; out_ready = 1'b1; reset = 1'b1;
        fwd_bus = mk_fwd(0, 1, 20, 16'h5555);
        #1;
        chk("midreset_pre_count", 64'(count), 64'd3);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fwd_bus = '0;
        #1;
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_out_operation", 64'(out_operation), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
